// File: rtl/video_timing_pkg.sv
// Shared phase encoding and default 640x480@60 timing for the video timing controller.
package video_timing_pkg;

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/sync_delay.sv
// LAT-stage shift register; reset fills every stage with the blanking word.
module sync_delay #(
    parameter int               WIDTH = 3,
    parameter int               LAT   = 2,
    parameter logic [WIDTH-1:0] BLANK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (LAT == 0) begin : g_direct
            assign dout = din;
        end else begin : g_pipe
            logic [LAT-1:0][WIDTH-1:0] stages;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stages <= {LAT{BLANK}};
                end else begin
                    stages[0] <= din;
                    for (int i = 1; i < LAT; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: h/v counters with phase FSMs, an undelayed pixel request,
// and sync/de outputs delayed to line up with the pixel source latency.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = 0,
    parameter int PIPE_LAT = 2
) (
    input  logic             PClk,
    input  logic             Reset,
    input  logic             Enable,
    output logic             pixelReq,
    output logic [CNT_W-1:0] pixelX,
    output logic [CNT_W-1:0] pixelY,
    output logic             frameStart,
    output logic             lineStart,
    output logic             hsync,
    output logic             vsync,
    output logic             activeArea
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Last count of each phase; the FSM advances on the edge leaving that count.
    localparam logic [CNT_W-1:0] H_A_END = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] H_F_END = CNT_W'(H_ACTIVE + H_FP - 1);
    localparam logic [CNT_W-1:0] H_S_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_A_END = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_F_END = CNT_W'(V_ACTIVE + V_FP - 1);
    localparam logic [CNT_W-1:0] V_S_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    localparam logic       POL   = SYNC_POL[0];
    localparam logic [2:0] BLANK = {~POL, ~POL, 1'b0};

    logic [CNT_W-1:0] h_count, v_count;
    phase_t           h_phase, v_phase;
    logic             h_wrap, v_wrap, run;
    logic [2:0]       raw, dly;

    assign h_wrap = (h_count == H_LAST);
    assign v_wrap = (v_count == V_LAST);
    assign run    = Enable && !Reset;

    always_ff @(posedge PClk) begin
        if (Reset || !Enable) begin
            h_count <= '0;
            v_count <= '0;
            h_phase <= ACTIVE;
            v_phase <= ACTIVE;
        end else begin
            h_count <= h_wrap ? '0 : h_count + 1'b1;
            unique case (h_phase)
                ACTIVE: if (h_count == H_A_END) h_phase <= FRONT;
                FRONT:  if (h_count == H_F_END) h_phase <= SYNC;
                SYNC:   if (h_count == H_S_END) h_phase <= BACK;
                BACK:   if (h_wrap)             h_phase <= ACTIVE;
            endcase
            if (h_wrap) begin
                v_count <= v_wrap ? '0 : v_count + 1'b1;
                unique case (v_phase)
                    ACTIVE: if (v_count == V_A_END) v_phase <= FRONT;
                    FRONT:  if (v_count == V_F_END) v_phase <= SYNC;
                    SYNC:   if (v_count == V_S_END) v_phase <= BACK;
                    BACK:   if (v_wrap)             v_phase <= ACTIVE;
                endcase
            end
        end
    end

    assign pixelReq   = run && (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign pixelX     = pixelReq ? h_count : '0;
    assign pixelY     = pixelReq ? v_count : '0;
    assign lineStart  = run && (h_count == '0);
    assign frameStart = lineStart && (v_count == '0);

    // A disabled generator feeds blanking into the delay line regardless of stale FSM state.
    assign raw = {(run && h_phase == SYNC) ? POL : ~POL,
                  (run && v_phase == SYNC) ? POL : ~POL,
                  pixelReq};

    sync_delay #(
        .WIDTH (3),
        .LAT   (PIPE_LAT),
        .BLANK (BLANK)
    ) u_sync_delay (
        .clk  (PClk),
        .rst  (Reset),
        .din  (raw),
        .dout (dly)
    );

    assign hsync      = Reset ? ~POL : dly[2];
    assign vsync      = Reset ? ~POL : dly[1];
    assign activeArea = Reset ? 1'b0 : dly[0];

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench: directed vector table, frame-level sequences on a scaled raster, and random
// Enable/Reset traffic checked against an arithmetic raster model for three configurations.
module tb_video_timing_ctrl;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic Enable = 1'b0;
    always #5 clk = ~clk;

    logic       pr [3];
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       fs [3];
    logic       ls [3];
    logic       hs [3];
    logic       vs [3];
    logic       de [3];

    // u0: defaults; u1: small raster for frame-level checks; u2: PIPE_LAT=0, SYNC_POL=1
    video_timing_ctrl u0 (
        .PClk(clk), .Reset(Reset), .Enable(Enable), .pixelReq(pr[0]), .pixelX(px[0]),
        .pixelY(py[0]), .frameStart(fs[0]), .lineStart(ls[0]), .hsync(hs[0]),
        .vsync(vs[0]), .activeArea(de[0]));

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(0), .PIPE_LAT(3)
    ) u1 (
        .PClk(clk), .Reset(Reset), .Enable(Enable), .pixelReq(pr[1]), .pixelX(px[1]),
        .pixelY(py[1]), .frameStart(fs[1]), .lineStart(ls[1]), .hsync(hs[1]),
        .vsync(vs[1]), .activeArea(de[1]));

    video_timing_ctrl #(.SYNC_POL(1), .PIPE_LAT(0)) u2 (
        .PClk(clk), .Reset(Reset), .Enable(Enable), .pixelReq(pr[2]), .pixelX(px[2]),
        .pixelY(py[2]), .frameStart(fs[2]), .lineStart(ls[2]), .hsync(hs[2]),
        .vsync(vs[2]), .activeArea(de[2]));

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, pol, lat;
    } cfg_t;

    cfg_t       cfg [3];
    int         m_cnt [3];
    logic [2:0] m_hist [3][8];
    logic [25:0] cur_obs [3];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Raw {hsync, vsync, de} for the cnt-th enabled cycle since restart.
    function automatic logic [2:0] raw_of(cfg_t c, int cnt, bit en);
        int ht = c.ha + c.hfp + c.hs + c.hbp;
        int vt = c.va + c.vfp + c.vs + c.vbp;
        int h = cnt % ht;
        int v = (cnt / ht) % vt;
        logic p = c.pol[0];
        logic h_s = (en && h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hs) ? p : ~p;
        logic v_s = (en && v >= c.va + c.vfp && v < c.va + c.vfp + c.vs) ? p : ~p;
        logic d = en && h < c.ha && v < c.va;
        return {h_s, v_s, d};
    endfunction

    function automatic logic [25:0] expect_vec(int i, bit r, bit e);
        cfg_t c = cfg[i];
        int ht = c.ha + c.hfp + c.hs + c.hbp;
        int vt = c.va + c.vfp + c.vs + c.vbp;
        int h = m_cnt[i] % ht;
        int v = (m_cnt[i] / ht) % vt;
        logic p = c.pol[0];
        logic [2:0] r3, d3;
        if (r) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, ~p, ~p, 1'b0};
        r3 = raw_of(c, m_cnt[i], e);
        d3 = (c.lat == 0) ? r3 : m_hist[i][c.lat-1];
        return {r3[0], r3[0] ? 10'(h) : 10'd0, r3[0] ? 10'(v) : 10'd0,
                e && h == 0 && v == 0, e && h == 0, d3};
    endfunction

    function automatic logic [25:0] obs(int i);
        return {pr[i], px[i], py[i], fs[i], ls[i], hs[i], vs[i], de[i]};
    endfunction

    task automatic step(input bit r, input bit e);
        logic [25:0] ev;
        @(negedge clk);
        Reset = r;
        Enable = e;
        #1;
        for (int i = 0; i < 3; i++) begin
            ev = expect_vec(i, r, e);
            cur_obs[i] = obs(i);
            checks++;
            if (cur_obs[i] !== ev) begin
                failures++;
                $display("FAIL model u%0d cyc=%0d got=%h exp=%h", i, cyc, cur_obs[i], ev);
            end
            if (r) begin
                for (int k = 0; k < 8; k++) m_hist[i][k] = {~cfg[i].pol[0], ~cfg[i].pol[0], 1'b0};
                m_cnt[i] = 0;
            end else begin
                for (int k = 7; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = raw_of(cfg[i], m_cnt[i], e);
                m_cnt[i] = e ? m_cnt[i] + 1 : 0;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    typedef struct {
        bit rst, en;
        int n, inst;
        bit pr;
        int x, y;
        bit fs, ls, hs, vs, de;
    } vec_t;

    vec_t vt [24];

    initial begin
        int fall, low, off_cnt;
        bit prev_v, r, e;
        int fs_q[$];
        logic [25:0] ev;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2};
        cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 2, 0, 3};
        cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0};
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            for (int k = 0; k < 8; k++) m_hist[i][k] = {~cfg[i].pol[0], ~cfg[i].pol[0], 1'b0};
        end

        //         rst en  n   inst pr  x   y  fs ls hs vs de
        vt[0]  = '{1, 1, 3,   0, 0, 0,   0, 0, 0, 1, 1, 0};
        vt[1]  = '{1, 1, 0,   2, 0, 0,   0, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 1,   0, 1, 0,   0, 1, 1, 1, 1, 0};  // cycle 0
        vt[3]  = '{0, 1, 0,   2, 1, 0,   0, 1, 1, 0, 0, 1};
        vt[4]  = '{0, 1, 2,   0, 1, 2,   0, 0, 0, 1, 1, 1};  // cycle 2: de up
        vt[5]  = '{0, 1, 638, 0, 0, 0,   0, 0, 0, 1, 1, 1};  // cycle 640
        vt[6]  = '{0, 1, 1,   0, 0, 0,   0, 0, 0, 1, 1, 1};
        vt[7]  = '{0, 1, 1,   0, 0, 0,   0, 0, 0, 1, 1, 0};  // cycle 642: de down
        vt[8]  = '{0, 1, 14,  2, 0, 0,   0, 0, 0, 1, 0, 0};  // cycle 656: u2 hsync high
        vt[9]  = '{0, 1, 0,   0, 0, 0,   0, 0, 0, 1, 1, 0};
        vt[10] = '{0, 1, 2,   0, 0, 0,   0, 0, 0, 0, 1, 0};  // cycle 658: u0 hsync low
        vt[11] = '{0, 1, 93,  2, 0, 0,   0, 0, 0, 1, 0, 0};  // cycle 751
        vt[12] = '{0, 1, 1,   2, 0, 0,   0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 1, 1,   0, 0, 0,   0, 0, 0, 0, 1, 0};  // cycle 753
        vt[14] = '{0, 1, 1,   0, 0, 0,   0, 0, 0, 1, 1, 0};
        vt[15] = '{0, 1, 46,  0, 1, 0,   1, 0, 1, 1, 1, 0};  // cycle 800: line 1
        vt[16] = '{0, 1, 0,   2, 1, 0,   1, 0, 1, 0, 0, 1};
        vt[17] = '{0, 1, 300, 0, 1, 300, 1, 0, 0, 1, 1, 1};  // x=300 y=1
        vt[18] = '{0, 0, 1,   0, 0, 0,   0, 0, 0, 1, 1, 1};  // Enable dropped
        vt[19] = '{0, 0, 1,   0, 0, 0,   0, 0, 0, 1, 1, 1};
        vt[20] = '{0, 0, 1,   0, 0, 0,   0, 0, 0, 1, 1, 0};
        vt[21] = '{0, 0, 2,   0, 0, 0,   0, 0, 0, 1, 1, 0};
        vt[22] = '{0, 1, 1,   0, 1, 0,   0, 1, 1, 1, 1, 0};  // re-enable at (0,0)
        vt[23] = '{0, 1, 0,   2, 1, 0,   0, 1, 1, 0, 0, 1};

        for (int k = 0; k < 24; k++) begin
            for (int s = 0; s < vt[k].n; s++) step(vt[k].rst, vt[k].en);
            ev = {vt[k].pr, 10'(vt[k].x), 10'(vt[k].y), vt[k].fs, vt[k].ls,
                  vt[k].hs, vt[k].vs, vt[k].de};
            checks++;
            if (cur_obs[vt[k].inst] !== ev) begin
                failures++;
                $display("FAIL vec[%0d] u%0d got=%h exp=%h", k, vt[k].inst, cur_obs[vt[k].inst], ev);
            end
        end

        // Scaled raster (15x9, latency 3): vsync lines 5..6 -> fall at 5*15+3, 30 low cycles.
        step(1, 1);
        step(1, 1);
        fall = -1;
        low = 0;
        prev_v = 1'b1;
        for (int k = 0; k < 300; k++) begin
            step(0, 1);
            if (prev_v && !cur_obs[1][1] && fall < 0) fall = k;
            if (k < 135 && !cur_obs[1][1]) low++;
            if (cur_obs[1][4]) fs_q.push_back(k);
            prev_v = cur_obs[1][1];
        end
        chk("vsync_fall", fall, 78);
        chk("vsync_low_cycles", low, 30);
        chk("frame_count", fs_q.size(), 3);
        if (fs_q.size() >= 2) chk("frame_period", fs_q[1] - fs_q[0], 135);

        // Reset pulsed during vsync: blank immediately, restart at (0,0).
        step(1, 1);
        for (int k = 0; k < 80; k++) step(0, 1);
        chk("pre_reset_vsync", int'(cur_obs[1][1]), 0);
        step(1, 1);
        chk("vsync_in_reset", int'(cur_obs[1][1]), 1);
        step(1, 1);
        chk("vsync_after_edge", int'(cur_obs[1][1]), 1);
        step(0, 1);
        chk("restart_vec", int'(cur_obs[1]), int'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}));

        // Random Enable drops and occasional resets.
        off_cnt = 0;
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 99) == 0);
            if (off_cnt > 0) begin
                e = 1'b0;
                off_cnt--;
            end else begin
                e = 1'b1;
                if ($urandom_range(0, 39) == 0) off_cnt = $urandom_range(1, 6);
            end
            step(r, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
